// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port IDs
// and a small one-hot helper used by the top level and the picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT1     = 1'b0;
  localparam logic PORT2     = 1'b1;
  localparam int   NUM_PORTS = 2;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic id);
    return (id == PORT2) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way round-robin picker: a lone eligible requester wins,
// a tie goes to the port that was not granted last.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_gnt,
  input  logic [NUM_PORTS-1:0] mask,
  output logic                 gnt_valid,
  output logic                 gnt_id
);

  logic [NUM_PORTS-1:0] eligible;

  assign eligible = req & ~mask;

  always_comb begin
    gnt_valid = |eligible;
    gnt_id    = PORT1;
    case (eligible)
      2'b01:   gnt_id = PORT1;
      2'b10:   gnt_id = PORT2;
      2'b11:   gnt_id = ~last_gnt;
      default: gnt_id = PORT1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between the fetch port (p1) and
// the data port (p2): two-cycle access, one-cycle ack, round-robin on ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  input  logic          p2_req,
  input  logic          p2_we,
  input  logic [AW-1:0] p2_addr,
  input  logic [DW-1:0] p2_wdata,
  output logic          p2_ack,
  output logic [DW-1:0] p2_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          cur_port
);

  state_t               state_reg;
  logic                 gnt_id_reg;
  logic                 we_reg;
  logic                 last_gnt_reg;
  logic [NUM_PORTS-1:0] ack_reg;
  logic                 mem_en_reg;
  logic                 mem_we_reg;
  logic [AW-1:0]        mem_addr_reg;
  logic [DW-1:0]        mem_wdata_reg;
  logic                 busy_reg;
  logic                 cur_port_reg;

  logic [NUM_PORTS-1:0] req_vec;
  logic [NUM_PORTS-1:0] mask;
  logic                 pick_valid;
  logic                 pick_id;
  logic                 sel_we;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;

  logic [NUM_PORTS-1:0][DW-1:0] rdata_vec;

  assign req_vec = {p2_req, p1_req};

  // In RESP the acked requester is still lowering its req, so hide it.
  assign mask = (state_reg == RESP) ? port_onehot(gnt_id_reg) : '0;

  mem_arb_rr_pick u_pick (
    .req       (req_vec),
    .last_gnt  (last_gnt_reg),
    .mask      (mask),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  always_comb begin
    sel_we    = p1_we;
    sel_addr  = p1_addr;
    sel_wdata = p1_wdata;
    if (pick_id == PORT2) begin
      sel_we    = p2_we;
      sel_addr  = p2_addr;
      sel_wdata = p2_wdata;
    end
  end

  // mem_addr/mem_wdata registers double as the latched request: they are
  // only needed during ACCESS, which is exactly when they are driven.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      gnt_id_reg    <= PORT1;
      we_reg        <= 1'b0;
      last_gnt_reg  <= PORT2;
      ack_reg       <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      busy_reg      <= 1'b0;
      cur_port_reg  <= PORT1;
    end else begin
      ack_reg       <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      case (state_reg)
        IDLE, RESP: begin
          if (pick_valid) begin
            state_reg     <= ACCESS;
            gnt_id_reg    <= pick_id;
            we_reg        <= sel_we;
            mem_en_reg    <= 1'b1;
            mem_we_reg    <= sel_we;
            mem_addr_reg  <= sel_addr;
            mem_wdata_reg <= sel_we ? sel_wdata : '0;
            busy_reg      <= 1'b1;
            cur_port_reg  <= pick_id;
          end else begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            cur_port_reg <= PORT1;
          end
        end
        ACCESS: begin
          state_reg    <= RESP;
          last_gnt_reg <= gnt_id_reg;
          ack_reg      <= port_onehot(gnt_id_reg);
          busy_reg     <= 1'b1;
        end
        default: begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          cur_port_reg <= PORT1;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [DW-1:0] hold_reg;
      logic          read_resp;

      assign read_resp = (state_reg == RESP) && (gnt_id_reg == 1'(gi)) && !we_reg;

      always_ff @(posedge clk) begin
        if (Reset) begin
          hold_reg <= '0;
        end else if (read_resp) begin
          hold_reg <= mem_rdata;
        end
      end

      assign rdata_vec[gi] = read_resp ? mem_rdata : hold_reg;
    end
  endgenerate

  assign p1_ack    = ack_reg[PORT1];
  assign p2_ack    = ack_reg[PORT2];
  assign p1_rdata  = rdata_vec[PORT1];
  assign p2_rdata  = rdata_vec[PORT2];
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;
  assign cur_port  = cur_port_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory, per-port
// expected-read-data queues checked on every ack, plus cycle-exact probes.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          p1_req = 1'b0, p2_req = 1'b0;
  logic          p1_we = 1'b0, p2_we = 1'b0;
  logic [AW-1:0] p1_addr = '0, p2_addr = '0;
  logic [DW-1:0] p1_wdata = '0, p2_wdata = '0;
  logic          p1_ack, p2_ack;
  logic [DW-1:0] p1_rdata, p2_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, cur_port;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {int port; int cyc;} ack_ev_t;
  ack_ev_t       ack_log[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_q2[$];
  logic [DW-1:0] exp_hold[1:2];
  logic [DW-1:0] ref_mem[int];
  logic [DW-1:0] mon_e1, mon_e2;

  logic [DW-1:0] mem_arr[65536];
  bit            mem_written[65536];

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .Reset(Reset),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
    .p2_ack(p2_ack), .p2_rdata(p2_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .cur_port(cur_port)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    case (a)
      16'h0001: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0010: return 16'hABCD;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  // Single-ported synchronous memory; read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_arr[mem_addr]     <= mem_wdata;
        mem_written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= mem_written[mem_addr] ? mem_arr[mem_addr] : init_word(mem_addr);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ack monitor: pops the expected read data of the acked port.
  always @(negedge clk) begin
    if (p1_ack || p2_ack) check_val("ack_onehot", 32'(p1_ack & p2_ack), 32'd0);
    if (p1_ack) begin
      ack_log.push_back('{1, cyc});
      if (exp_q1.size() == 0) check_val("p1_unexpected_ack", 32'(p1_ack), 32'd0);
      else begin
        mon_e1 = exp_q1.pop_front();
        $display("cycle %0d: p1 ack rdata=0x%h exp=0x%h", cyc, p1_rdata, mon_e1);
        check_val("p1_rdata_at_ack", 32'(p1_rdata), 32'(mon_e1));
      end
    end
    if (p2_ack) begin
      ack_log.push_back('{2, cyc});
      if (exp_q2.size() == 0) check_val("p2_unexpected_ack", 32'(p2_ack), 32'd0);
      else begin
        mon_e2 = exp_q2.pop_front();
        $display("cycle %0d: p2 ack rdata=0x%h exp=0x%h", cyc, p2_rdata, mon_e2);
        check_val("p2_rdata_at_ack", 32'(p2_rdata), 32'(mon_e2));
      end
    end
  end

  task automatic expect_ack(input int port, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
    logic [DW-1:0] e;
    if (we) begin
      ref_mem[int'(addr)] = wdata;
      e = exp_hold[port];
    end else begin
      e = ref_read(addr);
      exp_hold[port] = e;
    end
    if (port == 1) exp_q1.push_back(e);
    else           exp_q2.push_back(e);
  endtask

  task automatic drive_port(input int port, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port == 1) begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = req;
    end else begin
      p2_we = we; p2_addr = addr; p2_wdata = wdata; p2_req = req;
    end
  endtask

  // One requester transaction: raise req, wait (bounded) for ack, then drop req.
  task automatic port_access(input int port, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
    bit got = 1'b0;
    expect_ack(port, we, addr, wdata);
    drive_port(port, 1'b1, we, addr, wdata);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (port == 1) ? p1_ack : p2_ack;
    end
    if (!got) check_val("ack_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (port == 1) p1_req = 1'b0;
    else           p2_req = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ctrl"}, 32'({p1_ack, p2_ack, mem_en, mem_we, busy, cur_port}), 32'd0);
    check_val({tag, "_rdata"}, {p1_rdata, p2_rdata}, 32'd0);
    check_val({tag, "_bus"}, {mem_addr, mem_wdata}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    exp_hold[1] = '0;
    exp_hold[2] = '0;

    // Reset held 3 cycles with both requesters pending.
    drive_port(1, 1'b1, 1'b0, 16'h0001, '0);
    drive_port(2, 1'b1, 1'b0, 16'h0002, '0);
    expect_ack(1, 1'b0, 16'h0001, '0);
    expect_ack(2, 1'b0, 16'h0002, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("in_reset");
    end
    Reset = 1'b0;
    check_val("c0_mem_en", 32'({mem_en, busy}), 32'd0);
    tick();
    check_val("c1_p1_access", 32'({mem_en, mem_we, cur_port, busy}), 32'b1001);
    check_val("c1_addr", 32'(mem_addr), 32'h0001);
    tick();
    check_val("c2_acks", 32'({p1_ack, p2_ack}), 32'b10);
    check_val("c2_p1_rdata", 32'(p1_rdata), 32'h1111);
    tick();
    p1_req = 1'b0;
    check_val("c3_p2_access", 32'({mem_en, cur_port, busy, p1_ack}), 32'b1110);
    check_val("c3_addr", 32'(mem_addr), 32'h0002);
    tick();
    check_val("c4_acks", 32'({p1_ack, p2_ack, busy}), 32'b011);
    check_val("c4_p2_rdata", 32'(p2_rdata), 32'h2222);
    p2_req = 1'b0;
    tick();
    check_val("c5_idle", 32'({busy, cur_port, p2_ack}), 32'd0);
    check_val("c5_p1_hold", 32'(p1_rdata), 32'h1111);
    tick();

    // Next tie after p2 was served: p1 first.
    s = ack_log.size();
    fork
      port_access(1, 1'b0, 16'h0010, '0);
      port_access(2, 1'b1, 16'h0020, 16'h1234);
    join
    check_val("tie2_first_port", 32'(ack_log[s].port), 32'd1);
    check_val("p1_hold_after_drop", 32'(p1_rdata), 32'hABCD);
    check_val("p2_hold_after_write", 32'(p2_rdata), 32'h2222);
    tick();

    // Isolated p2 write, cycle exact.
    expect_ack(2, 1'b1, 16'h0030, 16'h5678);
    drive_port(2, 1'b1, 1'b1, 16'h0030, 16'h5678);
    tick();
    check_val("wr_access", 32'({mem_en, mem_we, cur_port}), 32'b111);
    check_val("wr_bus", {mem_addr, mem_wdata}, {16'h0030, 16'h5678});
    tick();
    check_val("wr_resp", 32'({p2_ack, mem_en, mem_we}), 32'b100);
    check_val("wr_resp_wdata", 32'(mem_wdata), 32'd0);
    check_val("wr_p2_rdata", 32'(p2_rdata), 32'h2222);
    p2_req = 1'b0;
    tick();

    // Reads from the other port see the new data; same port alone: 3-cycle spacing.
    s = ack_log.size();
    port_access(1, 1'b0, 16'h0020, '0);
    port_access(1, 1'b0, 16'h0030, '0);
    check_val("same_port_spacing", 32'(ack_log[s+1].cyc - ack_log[s].cyc), 32'd3);
    tick();

    // Continuous contention: alternating acks every 2 cycles, busy stays high.
    s = ack_log.size();
    fork
      for (int i = 0; i < 4; i++) port_access(1, 1'b0, 16'h0100 + 16'(i), '0);
      for (int i = 0; i < 4; i++) port_access(2, 1'b0, 16'h0200 + 16'(i), '0);
      begin
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check_val("busy_contention", 32'(busy), 32'd1);
        end
      end
    join
    check_val("contention_ack_count", 32'(ack_log.size() - s), 32'd8);
    for (int k = s + 1; k < ack_log.size(); k++) begin
      check_val("alternate_port", 32'(ack_log[k].port != ack_log[k-1].port), 32'd1);
      check_val("alternate_spacing", 32'(ack_log[k].cyc - ack_log[k-1].cyc), 32'd2);
    end
    tick();

    // Reset during p2's ACCESS: no ack, holds cleared, p1 wins the next tie.
    drive_port(2, 1'b1, 1'b0, 16'h0002, '0);
    tick();
    check_val("rst_pre_access", 32'({mem_en, cur_port}), 32'b11);
    Reset = 1'b1;
    tick();
    check_quiet("after_mid_reset");
    Reset = 1'b0;
    p2_req = 1'b0;
    exp_hold[1] = '0;
    exp_hold[2] = '0;
    tick();
    s = ack_log.size();
    fork
      port_access(1, 1'b0, 16'h0010, '0);
      port_access(2, 1'b0, 16'h0001, '0);
    join
    check_val("post_reset_first_port", 32'(ack_log[s].port), 32'd1);
    tick();

    check_val("p1_queue_drained", 32'(exp_q1.size()), 32'd0);
    check_val("p2_queue_drained", 32'(exp_q2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
